shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised universal shift register; the next generation of the team's fixed 4-bit serial-in/serial-out register.
- Adds configurable width, four operating modes (hold, shift right, shift left, parallel load), parallel output and a per-load shift counter with done pulse.
- Used as the serialiser/deserialiser building block in the CA lab datapath.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the remaining-shift counter (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the falling edge, as in the existing shift blocks.
- rst  input  1  synchronous active-high reset, sampled on the falling edge of clk.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering the MSB on a right shift.
- sin_l  input  1  serial input entering the LSB on a left shift.
- pin  input  WIDTH  parallel load data.
- pout  output  WIDTH  current register contents.
- sout  output  1  registered bit shifted out by the last shift (LSB for right, MSB for left).
- remain  output  CNT_W  shifts remaining since the last load.
- done  output  1  one-cycle pulse when remain reaches 0 through a shift.

Behaviour:
- Reset (rst=1 at a falling edge) overrides mode.
  - Reset values: pout=0, sout=0, remain=0, done=0, state=IDLE.
- Hold (00): pout and remain unchanged; sout holds; done=0.
- Shift right (01): pout <= {sin_r, pout[WIDTH-1:1]}; sout <= old pout[0].
- Shift left (10): pout <= {pout[WIDTH-2:0], sin_l}; sout <= old pout[WIDTH-1].
- Parallel load (11): pout <= pin; remain <= WIDTH; sout unchanged; done=0; state -> ACTIVE.
- Latency:
  - pout and sout reflect an operation at the first falling edge after mode is applied.
  - A serial bit on sin_r appears at pout[0] after WIDTH right shifts.
- Counter:
  - In ACTIVE, each shift decrements remain.
  - On the 1->0 transition, done=1 for exactly that cycle and state -> IDLE.
- IDLE:
  - Shifts still move data.
  - remain stays 0 (saturates, never wraps); done stays 0.
- Load during ACTIVE: restarts the count at WIDTH; no done pulse for the aborted sequence.
- Direction changes mid-sequence are legal; every shift counts regardless of direction.
- Reset mid-sequence: all state cleared at that edge; no done pulse.
- State machine: IDLE, ACTIVE only. Transitions:
  - IDLE -> ACTIVE on load.
  - ACTIVE -> IDLE on final shift or reset.
  - ACTIVE -> ACTIVE on load, hold, or non-final shift.

Optional Feature:
- Macro: SHIFT_REG_UNIV_ROTATE_EN.
- When defined:
  - Adds input port rot (1 bit).
  - With rot=1, shift right feeds old pout[0] into the MSB and shift left feeds old pout[WIDTH-1] into the LSB; sin_r and sin_l are ignored.
  - Counter and sout behaviour are unchanged.
- When undefined: rot port is absent; behaviour is as above.

Decomposition:
- Package shift_reg_pkg:
  - mode_t enum: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - state_t enum: IDLE, ACTIVE.
- Sub-module shift_cnt: loadable saturating down-counter with zero-crossing pulse, parametrised by CNT_W. It owns remain and done.
- The data path stays in the top module.

Test Plan:
- Reset: rst=1 for 2 edges with mode=11, pin=4'hF -> pout=0, sout=0, remain=0, done=0.
- Load and right-shift (WIDTH=4): load 4'b1011, then 4 shifts right with sin_r=0.
  - pout: 0101, 0010, 0001, 0000.
  - sout: 1, 1, 0, 1.
  - remain: 3, 2, 1, 0.
  - done=1 only on the 4th edge.
- Left shift / deserialise (WIDTH=8): feed 8'hA5 MSB-first on sin_l with mode=10 from pout=0 -> pout=8'hA5 after 8 edges; done never asserts (no load).
- Reload mid-sequence: load 4'h9, shift twice, load 4'h6 -> remain=4, no done; 4 further shifts -> done pulses once.
- Reset mid-sequence: load, shift once, assert rst -> all outputs 0 next edge; done stays 0 through 4 further shifts.
- Rotate (macro defined, WIDTH=4): load 4'b1000, rot=1, 4 right shifts -> pout 0100, 0010, 0001, 1000; done on the 4th edge.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operating modes and counter FSM states.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/shift_cnt.sv
// Loadable saturating down-counter with a one-cycle pulse on the 1->0 crossing.
// State advances on the falling edge of clk, matching the data path it tracks.
import shift_reg_pkg::*;

module shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] remain_o,
    output logic             done_o,
    output state_t           state_o
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Shifts in IDLE leave the count saturated at zero.
                    if (load_i) begin
                        cnt_q   <= load_val_i;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (load_i) begin
                        cnt_q <= load_val_i;
                    end else if (shift_i) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign remain_o = cnt_q;
    assign done_o   = done_q;
    assign state_o  = state_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load with a per-load shift counter.
// Optional rotate input enabled by defining SHIFT_REG_UNIV_ROTATE_EN.
import shift_reg_pkg::*;

module shift_reg_univ #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic [CNT_W-1:0] remain,
    output logic             done,
    output state_t           state_dbg
);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic             sout_q, sout_d;
    logic             fill_r, fill_l;
    logic             load, shift;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign fill_r = rot ? pout_q[0]       : sin_r;
    assign fill_l = rot ? pout_q[WIDTH-1] : sin_l;
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif

    assign load  = (mode_t'(mode) == MODE_LOAD);
    assign shift = (mode_t'(mode) == MODE_SHR) || (mode_t'(mode) == MODE_SHL);

    always_comb begin
        pout_d = pout_q;
        sout_d = sout_q;
        case (mode_t'(mode))
            MODE_SHR: begin
                pout_d = {fill_r, pout_q[WIDTH-1:1]};
                sout_d = pout_q[0];
            end
            MODE_SHL: begin
                pout_d = {pout_q[WIDTH-2:0], fill_l};
                sout_d = pout_q[WIDTH-1];
            end
            MODE_LOAD: pout_d = pin;
            default: ;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            pout_q <= '0;
            sout_q <= 1'b0;
        end else begin
            pout_q <= pout_d;
            sout_q <= sout_d;
        end
    end

    shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .shift_i    (shift),
        .load_val_i (CNT_W'(WIDTH)),
        .remain_o   (remain),
        .done_o     (done),
        .state_o    (state_dbg)
    );

    assign pout = pout_q;
    assign sout = sout_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: a 4-bit instance driven from a vector table through an
// expected-value queue, plus an 8-bit instance for the deserialise sequence.
import shift_reg_pkg::*;

module tb_shift_reg_univ;

  localparam int W  = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [W-1:0]  pout;
    logic          sout;
    logic [CW-1:0] remain;
    logic          done;
  } exp_t;

  typedef struct packed {
    logic         rst;
    logic [1:0]   mode;
    logic         sr;
    logic         sl;
    logic [W-1:0] pin;
    logic         rt;
    exp_t         e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic          sin_r, sin_l;
  logic [W-1:0]  pin;
  logic [W-1:0]  pout;
  logic          sout;
  logic [CW-1:0] remain;
  logic          done;
  state_t        state_dbg;

  logic [1:0]    mode8;
  logic          sin_l8;
  logic [7:0]    pin8;
  logic [7:0]    pout8;
  logic          sout8;
  logic [3:0]    remain8;
  logic          done8;
  state_t        state8;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  logic          rot;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  // clock / reset: state changes on negedge, so the bench drives and samples on posedge
  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot       (rot),
`endif
    .pin       (pin),
    .pout      (pout),
    .sout      (sout),
    .remain    (remain),
    .done      (done),
    .state_dbg (state_dbg)
  );

  shift_reg_univ #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode8),
    .sin_r     (1'b0),
    .sin_l     (sin_l8),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot       (1'b0),
`endif
    .pin       (pin8),
    .pout      (pout8),
    .sout      (sout8),
    .remain    (remain8),
    .done      (done8),
    .state_dbg (state8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [1:0] m, input logic sr, input logic sl,
                              input logic [W-1:0] p, input logic rt, input logic [W-1:0] e_pout,
                              input logic e_sout, input logic [CW-1:0] e_rem, input logic e_done);
    vec_t v;
    v.rst = r; v.mode = m; v.sr = sr; v.sl = sl; v.pin = p; v.rt = rt;
    v.e.pout = e_pout; v.e.sout = e_sout; v.e.remain = e_rem; v.e.done = e_done;
    vecs.push_back(v);
  endfunction

  // driver: apply one vector at posedge, queue its expectation
  task automatic drive(input vec_t v);
    rst   = v.rst;
    mode  = v.mode;
    sin_r = v.sr;
    sin_l = v.sl;
    pin   = v.pin;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    rot   = v.rt;
`endif
    exp_q.push_back(v.e);
  endtask

  // scoreboard: pop after the falling edge has updated the DUT
  task automatic score(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("queue_empty[%0d]", idx), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("pout[%0d]", idx),   32'(pout),   32'(e.pout));
      check($sformatf("sout[%0d]", idx),   32'(sout),   32'(e.sout));
      check($sformatf("remain[%0d]", idx), 32'(remain), 32'(e.remain));
      check($sformatf("done[%0d]", idx),   32'(done),   32'(e.done));
      check($sformatf("state[%0d]", idx), 32'(state_dbg), (e.remain != 0) ? 32'(ACTIVE) : 32'(IDLE));
    end
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      @(posedge clk);
      score(i);
    end
    if (exp_q.size() != 0) check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] exp8;
    rst = 1'b1; mode = 2'b11; sin_r = 1'b0; sin_l = 1'b0; pin = 4'hF;
    mode8 = 2'b00; sin_l8 = 1'b0; pin8 = 8'hFF;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    rot = 1'b0;
`endif
    @(posedge clk);

    // reset with load requested, then load 1011 and serialise right
    add(1, 2'b11, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0);
    add(1, 2'b11, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 0);
    add(0, 2'b11, 0, 0, 4'hB, 0, 4'b1011, 0, 4, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0101, 1, 3, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0010, 1, 2, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0001, 0, 1, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0000, 1, 0, 1);
    add(0, 2'b00, 0, 0, 4'h0, 0, 4'b0000, 1, 0, 0);
    // idle shifts still move data, count saturates
    add(0, 2'b01, 1, 0, 4'h0, 0, 4'b1000, 0, 0, 0);
    add(0, 2'b10, 0, 1, 4'h0, 0, 4'b0001, 1, 0, 0);
    // reload mid-sequence, direction changes, holds
    add(0, 2'b11, 0, 0, 4'h9, 0, 4'b1001, 1, 4, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0100, 1, 3, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0010, 0, 2, 0);
    add(0, 2'b11, 0, 0, 4'h6, 0, 4'b0110, 0, 4, 0);
    add(0, 2'b10, 0, 0, 4'h0, 0, 4'b1100, 0, 3, 0);
    add(0, 2'b01, 1, 0, 4'h0, 0, 4'b1110, 0, 2, 0);
    add(0, 2'b00, 0, 0, 4'h0, 0, 4'b1110, 0, 2, 0);
    add(0, 2'b10, 0, 1, 4'h0, 0, 4'b1101, 1, 1, 0);
    add(0, 2'b10, 0, 0, 4'h0, 0, 4'b1010, 1, 0, 1);
    add(0, 2'b00, 0, 0, 4'h0, 0, 4'b1010, 1, 0, 0);
    // reset mid-sequence, then shifts must not produce done
    add(0, 2'b11, 0, 0, 4'h3, 0, 4'b0011, 1, 4, 0);
    add(0, 2'b01, 0, 0, 4'h0, 0, 4'b0001, 1, 3, 0);
    add(1, 2'b01, 1, 0, 4'h0, 0, 4'b0000, 0, 0, 0);
    add(0, 2'b10, 0, 1, 4'h0, 0, 4'b0001, 0, 0, 0);
    add(0, 2'b10, 0, 1, 4'h0, 0, 4'b0011, 0, 0, 0);
    add(0, 2'b10, 0, 1, 4'h0, 0, 4'b0111, 0, 0, 0);
    add(0, 2'b10, 0, 1, 4'h0, 0, 4'b1111, 0, 0, 0);
    add(0, 2'b10, 0, 0, 4'h0, 0, 4'b1110, 1, 0, 0);
    run_vectors("main");

    // 8-bit deserialise: A5 MSB-first on sin_l, no load so no done
    mode = 2'b00;
    check("pout8_start", 32'(pout8), 32'h00);
    pat  = 8'hA5;
    exp8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mode8  = 2'b10;
      sin_l8 = pat[7-i];
      exp8   = {exp8[6:0], pat[7-i]};
      @(negedge clk);
      @(posedge clk);
      check($sformatf("pout8[%0d]", i), 32'(pout8), 32'(exp8));
      check($sformatf("done8[%0d]", i), 32'(done8), 32'd0);
      check($sformatf("remain8[%0d]", i), 32'(remain8), 32'd0);
    end
    check("pout8_final", 32'(pout8), 32'hA5);
    mode8 = 2'b00;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // rotate: serial inputs ignored, counter unchanged
    add(0, 2'b11, 0, 0, 4'b1000, 0, 4'b1000, 1, 4, 0);
    add(0, 2'b01, 1, 1, 4'h0,    1, 4'b0100, 0, 3, 0);
    add(0, 2'b01, 1, 1, 4'h0,    1, 4'b0010, 0, 2, 0);
    add(0, 2'b01, 1, 1, 4'h0,    1, 4'b0001, 0, 1, 0);
    add(0, 2'b01, 1, 1, 4'h0,    1, 4'b1000, 1, 0, 1);
    add(0, 2'b10, 0, 0, 4'h0,    1, 4'b0001, 1, 0, 0);
    run_vectors("rotate");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
